img_proc_engine: RTL and testbench



---
 rtl/img_proc_pkg.sv | 11 +
 rtl/img_proc_if.sv | 19 +
 rtl/img_proc_sharpen_acc.sv | 24 ++
 rtl/img_proc_engine.sv | 97 +++++++++
 tb/tb_img_proc_engine.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/img_proc_pkg.sv
// img_proc_pkg: mode codes, FSM state codes, sharpen neighbour table and weights
package img_proc_pkg;
  localparam logic [1:0] MODE_MIR = 2'd0, MODE_GRAY = 2'd1, MODE_SH = 2'd2;
  localparam logic [2:0] S_IDLE = 3'd0, S_MIR_RD = 3'd1, S_MIR_WR = 3'd2, S_GRAY = 3'd3,
                         S_SH_ACC = 3'd4, S_SH_WR = 3'd5, S_DONE = 3'd6;
  typedef logic signed [4:0] wgt_t;
  localparam wgt_t W_CTR = 5'sd9, W_NB = -5'sd1;
  typedef logic signed [1:0] off_t;
  localparam off_t DR [9] = '{2'sd0, -2'sd1, -2'sd1, -2'sd1, 2'sd0, 2'sd0, 2'sd1, 2'sd1, 2'sd1};
  localparam off_t DC [9] = '{2'sd0, -2'sd1, 2'sd0, 2'sd1, -2'sd1, 2'sd1, -2'sd1, 2'sd0, 2'sd1};
endpackage

// File: rtl/img_proc_if.sv
// img_proc_if: command, pixel read and pixel write bundle of the image engine
interface img_proc_if #(
  parameter int ROWS = 64,
  parameter int COLS = 64,
  parameter int CH_W = 8,
  parameter int CH_N = 3
);
  logic start;
  logic [1:0] mode;
  logic [CH_N*CH_W-1:0] in_pix;
  logic [$clog2(ROWS)-1:0] row;
  logic [$clog2(COLS)-1:0] col;
  logic out_we;
  logic [CH_N*CH_W-1:0] out_pix;
  logic busy;
  logic done;
  modport master (output start, mode, in_pix, input row, col, out_we, out_pix, busy, done);
  modport slave (input start, mode, in_pix, output row, col, out_we, out_pix, busy, done);
endinterface

// File: rtl/img_proc_sharpen_acc.sv
// sharpen_acc: one channel's signed sharpen accumulator; IMG_PROC_SATURATE_EN clamps, else wraps
module sharpen_acc import img_proc_pkg::*; #(
  parameter int CH_W = 8,
  parameter int AW = CH_W + 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic add,
  input  wgt_t w,
  input  logic [CH_W-1:0] pix,
  output logic [CH_W-1:0] res
);
  logic signed [AW-1:0] acc_q, acc_d;
  // clear between pixels, otherwise fold in the weighted sample
  always_comb acc_d = clr ? '0 : add ? acc_q + AW'(signed'({1'b0, pix})) * AW'(w) : acc_q;
  // accumulator register
  always_ff @(posedge clk) acc_q <= rst ? '0 : acc_d;
`ifdef IMG_PROC_SATURATE_EN
  assign res = acc_q < 0 ? '0 : acc_q > AW'((1 << CH_W) - 1) ? '1 : acc_q[CH_W-1:0];
`else
  assign res = acc_q[CH_W-1:0];
`endif
endmodule

// File: rtl/img_proc_engine.sv
// img_proc_engine: mirror/grayscale/sharpen sequencer; IMG_PROC_SATURATE_EN clamps sharpen results
module img_proc_engine import img_proc_pkg::*; #(
  parameter int ROWS = 64,
  parameter int COLS = 64,
  parameter int CH_W = 8,
  parameter int CH_N = 3,
  parameter int GRAY_CH = 1
) (
  input logic clk,
  input logic rst,
  img_proc_if.slave bus
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int PW = CH_N * CH_W;
  localparam logic [RW-1:0] RMAX = RW'(ROWS - 1);
  localparam logic [CW-1:0] CMAX = CW'(COLS - 1);
  logic [2:0] state_q, state_d;
  logic [RW-1:0] r_q, r_d;
  logic [CW-1:0] c_q, c_d;
  logic [3:0] k_q, k_d;
  logic [PW-1:0] cap_q, cap_d, pix_q, pix_d, gray_pix, sh_pix, wr_pix;
  logic [CH_W-1:0] ch_r, ch_g, ch_b, mx, mn;
  logic [CH_W:0] sum;
  logic border, last, we, acc_clr, acc_add;
  wgt_t acc_w;
  assign ch_r = bus.in_pix[2*CH_W +: CH_W];
  assign ch_g = bus.in_pix[CH_W +: CH_W];
  assign ch_b = bus.in_pix[0 +: CH_W];
  assign mx = ch_r > ch_g ? (ch_r > ch_b ? ch_r : ch_b) : (ch_g > ch_b ? ch_g : ch_b);
  assign mn = ch_r < ch_g ? (ch_r < ch_b ? ch_r : ch_b) : (ch_g < ch_b ? ch_g : ch_b);
  assign sum = {1'b0, mx} + {1'b0, mn};
  // grayscale lands on one channel, the rest stay zero
  always_comb begin
    gray_pix = '0;
    gray_pix[GRAY_CH*CH_W +: CH_W] = CH_W'(sum >> 1);
  end
  assign border = r_q == '0 || r_q == RMAX || c_q == '0 || c_q == CMAX;
  assign last = r_q == RMAX && c_q == CMAX;
  assign we = state_q == S_MIR_WR || state_q == S_GRAY || state_q == S_SH_WR || (state_q == S_SH_ACC && border);
  assign wr_pix = state_q == S_MIR_WR ? cap_q : state_q == S_GRAY ? gray_pix : state_q == S_SH_WR ? sh_pix : bus.in_pix;
  assign acc_clr = state_q == S_IDLE || state_q == S_SH_WR;
  assign acc_add = state_q == S_SH_ACC && !border;
  assign acc_w = k_q == '0 ? W_CTR : W_NB;
  for (genvar i = 0; i < CH_N; i++) begin : g_acc
    sharpen_acc #(.CH_W(CH_W)) u_acc (
      .clk(clk), .rst(rst), .clr(acc_clr), .add(acc_add), .w(acc_w),
      .pix(bus.in_pix[i*CH_W +: CH_W]), .res(sh_pix[i*CH_W +: CH_W])
    );
  end
  // every write advances the row-major scan; the final pixel wraps the counters to zero
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    c_d = we ? (c_q == CMAX ? '0 : c_q + 1'b1) : c_q;
    r_d = we ? (last ? '0 : c_q == CMAX ? r_q + 1'b1 : r_q) : r_q;
    cap_d = state_q == S_MIR_RD ? bus.in_pix : cap_q;
    pix_d = we ? wr_pix : pix_q;
    case (state_q)
      S_IDLE: state_d = !bus.start ? S_IDLE : bus.mode == MODE_MIR ? S_MIR_RD :
                        bus.mode == MODE_GRAY ? S_GRAY : bus.mode == MODE_SH ? S_SH_ACC : S_DONE;
      S_MIR_RD: state_d = S_MIR_WR;
      S_MIR_WR: state_d = last ? S_DONE : S_MIR_RD;
      S_GRAY: state_d = last ? S_DONE : S_GRAY;
      S_SH_ACC: begin
        state_d = border ? (last ? S_DONE : S_SH_ACC) : k_q == 4'd8 ? S_SH_WR : S_SH_ACC;
        k_d = border || k_q == 4'd8 ? '0 : k_q + 1'b1;
      end
      S_SH_WR: state_d = last ? S_DONE : S_SH_ACC;
      default: state_d = S_IDLE;
    endcase
  end
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      r_q <= '0;
      c_q <= '0;
      k_q <= '0;
      cap_q <= '0;
      pix_q <= '0;
    end else begin
      state_q <= state_d;
      r_q <= r_d;
      c_q <= c_d;
      k_q <= k_d;
      cap_q <= cap_d;
      pix_q <= pix_d;
    end
  end
  assign bus.out_we = we;
  assign bus.out_pix = pix_d;
  assign bus.row = state_q == S_MIR_RD ? RMAX - r_q : state_q == S_SH_ACC ? r_q + RW'(DR[k_q]) : r_q;
  assign bus.col = state_q == S_SH_ACC ? c_q + CW'(DC[k_q]) : c_q;
  assign bus.busy = state_q != S_IDLE && state_q != S_DONE;
  assign bus.done = state_q == S_DONE;
endmodule

// File: tb/tb_img_proc_engine.sv
// tb_img_proc_engine: directed checks of img_proc_engine against a pixel-level image model
module tb_img_proc_engine;
  localparam int R = 8, C = 16, CW = 8, CN = 3, GC = 1, PW = CW * CN, MAXV = (1 << CW) - 1;
`ifdef IMG_PROC_SATURATE_EN
  localparam int SH_HI = 255, SH_LO = 0;
`else
  localparam int SH_HI = 52, SH_LO = 141;
`endif
  logic clk = 0, rst = 1, rst_seen = 1;
  logic [PW-1:0] img [R][C];
  logic [PW-1:0] exp_img [R][C];
  logic [PW-1:0] out_img [R][C];
  logic [PW-1:0] last_wr = '0;
  int n_cmp = 0, n_bad = 0, wr_cnt = 0;

  img_proc_if #(.ROWS(R), .COLS(C), .CH_W(CW), .CH_N(CN)) bus ();
  img_proc_engine #(.ROWS(R), .COLS(C), .CH_W(CW), .CH_N(CN), .GRAY_CH(GC)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  always #5 clk = ~clk;
  assign bus.in_pix = img[bus.row][bus.col];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  function automatic logic [PW-1:0] gray_of(input logic [PW-1:0] p);
    int r, g, b, mx, mn;
    logic [PW-1:0] o;
    r = int'(p[2*CW +: CW]);
    g = int'(p[CW +: CW]);
    b = int'(p[0 +: CW]);
    mx = r > g ? (r > b ? r : b) : (g > b ? g : b);
    mn = r < g ? (r < b ? r : b) : (g < b ? g : b);
    o = '0;
    o[GC*CW +: CW] = CW'((mx + mn) / 2);
    return o;
  endfunction

  function automatic int sh_val(input int centre, input int nsum);
    int v;
    v = 9 * centre - nsum;
`ifdef IMG_PROC_SATURATE_EN
    return v < 0 ? 0 : v > MAXV ? MAXV : v;
`else
    return v & MAXV;
`endif
  endfunction

  task automatic build_exp(input logic [1:0] m);
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) begin
        out_img[r][c] = 'x;
        if (m == 2'd0) exp_img[r][c] = img[R-1-r][c];
        else if (m == 2'd1) exp_img[r][c] = gray_of(img[r][c]);
        else if (r == 0 || r == R - 1 || c == 0 || c == C - 1) exp_img[r][c] = img[r][c];
        else
          for (int k = 0; k < CN; k++) begin
            int s;
            s = 0;
            for (int dr = -1; dr <= 1; dr++)
              for (int dc = -1; dc <= 1; dc++)
                if (dr != 0 || dc != 0) s += int'(img[r+dr][c+dc][k*CW +: CW]);
            exp_img[r][c][k*CW +: CW] = CW'(sh_val(int'(img[r][c][k*CW +: CW]), s));
          end
      end
  endtask

  initial forever begin
    @(posedge clk);
    rst_seen = rst;
  end

  initial forever begin
    @(negedge clk);
    if (rst_seen) last_wr = '0;
    if (bus.out_we) begin
      wr_cnt++;
      check("pix", bus.out_pix, exp_img[bus.row][bus.col]);
      check("busy_we", bus.busy, 1);
      out_img[bus.row][bus.col] = bus.out_pix;
      last_wr = bus.out_pix;
    end else check("hold", bus.out_pix, last_wr);
  end

  task automatic run_op(input string name, input logic [1:0] m, input int total, input int writes, input int poke);
    int n;
    if (m != 2'd3) build_exp(m);
    wr_cnt = 0;
    @(negedge clk);
    bus.mode = m;
    bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    n = 1;
    if (total > 0) begin
      check({name, "_busy1"}, bus.busy, 1);
      check({name, "_row1"}, bus.row, m == 2'd0 ? R - 1 : 0);
      check({name, "_col1"}, bus.col, 0);
    end
    while (!bus.done && n < 4 * total + 8) begin
      bus.start = n == poke;
      if (n == poke) bus.mode = 2'd0;
      @(negedge clk);
      n++;
    end
    bus.start = 0;
    check({name, "_cycles"}, n, total + 1);
    check({name, "_done"}, bus.done, 1);
    check({name, "_writes"}, wr_cnt, writes);
    @(negedge clk);
    check({name, "_pulse"}, {bus.done, bus.busy, bus.out_we}, 0);
  endtask

  initial begin
    bus.start = 0;
    bus.mode = 0;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) img[r][c] = {CN{CW'(r)}};
    repeat (3) @(negedge clk);
    check("rst_ctl", {bus.busy, bus.done, bus.out_we}, 0);
    check("rst_pix", bus.out_pix, 0);
    check("rst_addr", {bus.row, bus.col}, 0);
    rst = 0;
    check("pin_gray_a", gray_of(24'h30C080), 24'h007800);
    check("pin_gray_b", gray_of(24'hFFFFFF), 24'h00FF00);
    check("pin_sh_hi", sh_val(100, 80), SH_HI);
    check("pin_sh_lo", sh_val(5, 160), SH_LO);

    run_op("mir", 2'd0, 2 * R * C, R * C, -1);
    check("mir_lit_top", out_img[0][0], 24'h070707);
    check("mir_lit_bot", out_img[R-1][C-1], 24'h000000);
    check("mir_lit_mid", out_img[2][9], 24'h050505);

    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) img[r][c] = PW'($urandom);
    img[1][2] = 24'h30C080;
    img[3][4] = 24'hFFFFFF;
    run_op("gray", 2'd1, R * C, R * C, 20);
    check("gray_lit_a", out_img[1][2], 24'h007800);
    check("gray_lit_b", out_img[3][4], 24'h00FF00);

    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) img[r][c] = PW'($urandom);
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++) begin
        img[2+dr][2+dc] = {CN{8'd10}};
        img[5+dr][10+dc] = {CN{8'd20}};
      end
    img[2][2] = {CN{8'd100}};
    img[5][10] = {CN{8'd5}};
    run_op("sh", 2'd2, (R - 2) * (C - 2) * 10 + R * C - (R - 2) * (C - 2), R * C, -1);
    check("sh_lit_hi", out_img[2][2], {CN{CW'(SH_HI)}});
    check("sh_lit_lo", out_img[5][10], {CN{CW'(SH_LO)}});
    check("sh_border_a", out_img[0][0], img[0][0]);
    check("sh_border_b", out_img[R-1][7], img[R-1][7]);
    check("sh_border_c", out_img[3][C-1], img[3][C-1]);

    run_op("rsv", 2'd3, 0, 0, -1);

    build_exp(2'd1);
    wr_cnt = 0;
    @(negedge clk);
    bus.mode = 2'd1;
    bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    repeat (99) @(negedge clk);
    rst = 1;
    @(negedge clk);
    check("abort_out", {bus.out_we, bus.busy, bus.done}, 0);
    rst = 0;
    repeat (3) begin
      @(negedge clk);
      check("abort_idle", {bus.out_we, bus.busy, bus.done}, 0);
    end
    check("abort_writes", wr_cnt, 100);
    run_op("gray2", 2'd1, R * C, R * C, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
